word_serializer: RTL and testbench
==================================

# word_serializer

Parallel-to-serial transmitter that accepts one WIDTH-bit word per valid/ready handshake and shifts it out one bit per advance strobe, with a frame-valid and last-bit marker. It is the transmit end of the team's serial word link: the downstream deserializer rebuilds the word and lands it in an 8-bit register. The shift rate is paced by an external strobe. A word can be accepted during the last bit of the current word, so back-to-back words stream without a gap.

## Interface
- WIDTH, 8: word width in bits; must be ≥ 2.
- MSB_FIRST, 1: 1 shifts bit WIDTH-1 first, 0 shifts bit 0 first.

- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high; it is sampled only on the rising edge of clk.
- in_word  in  WIDTH  word to transmit; sampled only on the handshake edge.
- in_valid  in  1  in_word is valid.
- in_ready  out  1  block can accept a word this cycle.
- bit_en  in  1  advance strobe; the current bit retires on an edge where bit_en=1.
- ser_data  out  1  current serial bit.
- ser_valid  out  1  ser_data is part of a word.
- ser_last  out  1  ser_data is the final bit of the word.
- busy  out  1  a word is in flight (same as ser_valid).

## Operation
- FSM states: S_IDLE and S_SHIFT.
- Registers: a WIDTH-bit shift register `shreg` and a bit index `idx` holding 0..WIDTH-1.
- A handshake occurs when in_valid && in_ready on a rising edge.
- In S_IDLE: in_ready=1, ser_valid=0, and bit_en is ignored.
  - On handshake: shreg ← in_word, idx ← 0, go to S_SHIFT.
- In S_SHIFT:
  - ser_valid=1.
  - ser_data = shreg[WIDTH-1] when MSB_FIRST=1, else shreg[0].
  - ser_last = (idx == WIDTH-1).
- On an edge with bit_en=1 and idx < WIDTH-1:
  - Shift shreg toward the output end, zero-filled.
  - idx ← idx+1.
- On an edge with bit_en=1 and idx == WIDTH-1, the word is complete:
  - With a handshake: reload shreg, idx ← 0, stay in S_SHIFT.
  - Without a handshake: go to S_IDLE.
- in_ready = S_IDLE || (S_SHIFT && ser_last && bit_en). It is combinational from state and bit_en, and no combinational path runs from in_valid to in_ready.
- A handshake in any other cycle is impossible, because in_ready=0.
- Changes to in_word after its handshake have no effect on the word in flight.
- Edges with bit_en=0 in S_SHIFT hold all state.
- Reset values:
  - State S_IDLE; shreg, idx, ser_data, ser_valid, ser_last and busy all 0.
  - in_ready is forced to 0 while reset=1.
- Reset mid-word aborts the word. The partial word is discarded and no ser_last is issued.

## Timing
- Handshake at edge N → ser_valid=1 and the first bit are visible after edge N (1-cycle latency).
- Each bit is held until the first subsequent edge with bit_en=1.
- With bit_en tied to 1:
  - A word occupies exactly WIDTH cycles.
  - Sustained throughput is one word per WIDTH cycles, with no idle cycle between back-to-back words.
- ser_last is high for exactly the hold duration of the final bit.
- Reset asserted at edge M → all outputs at reset values after edge M.
  - in_ready goes to 1 in the first cycle with reset=0.

## Structure
- Package `serial_pkg`:
  - `state_t` enum {S_IDLE, S_SHIFT}.
  - `DEFAULT_WIDTH = 8`.
- Sub-module `mod_counter`:
  - Parameterised modulo-WIDTH index counter with enable, synchronous clear and a terminal-count output.
  - It drives idx and ser_last.
- The FSM, shift register and handshake logic stay in word_serializer.

## Test plan
- WIDTH=8, MSB_FIRST=1, bit_en=1, send 8'hA5 → ser_data 1,0,1,0,0,1,0,1 on cycles 1–8.
  - ser_valid=1 for 8 cycles, ser_last=1 only on cycle 8, ser_valid=0 on cycle 9.
- Back-to-back 8'h01 then 8'hFF with in_valid held high → 16 contiguous valid bits, 0000000111111111.
  - ser_last on bits 8 and 16; in_ready pulses on bit 8.
- bit_en toggling 1,0,1,0… while sending 8'h3C → each bit held 2 cycles; word spans 16 cycles.
  - in_word changed to 8'hFF one cycle after the handshake → output unchanged.
- Send 8'hF0, assert reset for 1 cycle after 3 bits → next cycle ser_valid=0, ser_last=0, busy=0, in_ready=1.
  - A following 8'h0F is transmitted in full and correct.
- MSB_FIRST=0, send 8'h01 → ser_data 1 then seven 0s.
  - Send 8'h80 → seven 0s then 1, with ser_last on the 1.

Source files
------------

// File: rtl/word_serializer_pkg.sv
// Shared types and defaults for the serial word link transmitter.
package serial_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/word_serializer_if.sv
// Word-in / bit-out bundle between an upstream producer and word_serializer.
interface word_serializer_if
  import serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic [WIDTH-1:0] in_word;
  logic             in_valid;
  logic             in_ready;
  logic             bit_en;
  logic             ser_data;
  logic             ser_valid;
  logic             ser_last;
  logic             busy;

  modport master (
    output in_word, in_valid, bit_en,
    input  in_ready, ser_data, ser_valid, ser_last, busy
  );

  modport slave (
    input  in_word, in_valid, bit_en,
    output in_ready, ser_data, ser_valid, ser_last, busy
  );
endinterface

// File: rtl/word_serializer_counter.sv
// Modulo-WIDTH bit index counter; tc flags the final index of a word.
module mod_counter #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          tc
);

  assign tc = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset || clr) cnt <= '0;
    else if (en)      cnt <= tc ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/word_serializer.sv
// Parallel-to-serial transmitter: one word per handshake, one bit per bit_en strobe,
// with reload on the final bit so back-to-back words stream without a gap.
module word_serializer
  import serial_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  word_serializer_if.slave   bus
);

  localparam int CW = $clog2(WIDTH);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    idx;
  logic             tc;
  logic             shifting;
  logic             in_ready;
  logic             hs;
  logic             advance;

  assign shifting = (state == S_SHIFT);
  assign advance  = shifting && bus.bit_en;
  assign hs       = bus.in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // in_ready depends only on state, bit_en and reset, never on in_valid.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    unique case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        in_ready = tc && bus.bit_en;
        if (tc && bus.bit_en && !bus.in_valid) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (reset) in_ready = 1'b0;
  end

  // The final shift leaves shreg all-zero, so an idle block holds no stale data.
  always_ff @(posedge clk) begin
    if (reset)        shreg <= '0;
    else if (hs)      shreg <= bus.in_word;
    else if (advance) shreg <= MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0}
                                         : {1'b0, shreg[WIDTH-1:1]};
  end

  mod_counter #(.WIDTH(WIDTH), .CW(CW)) u_idx (
    .clk   (clk),
    .reset (reset),
    .clr   (hs),
    .en    (advance),
    .cnt   (idx),
    .tc    (tc)
  );

  assign bus.in_ready  = in_ready;
  assign bus.ser_valid = shifting;
  assign bus.busy      = shifting;
  assign bus.ser_last  = shifting && tc;
  assign bus.ser_data  = shifting && (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]);

endmodule

// File: tb/tb_word_serializer.sv
// Directed table-driven bench for word_serializer (MSB-first and LSB-first instances).
module tb_word_serializer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  word_serializer_if #(.WIDTH(8)) bus_m ();
  word_serializer_if #(.WIDTH(8)) bus_l ();

  word_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_m.slave)
  );

  word_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_l.slave)
  );

  typedef struct {
    bit       lsb;
    bit       rst;
    bit       valid;
    bit [7:0] word;
    bit       be;
    bit       sd;
    bit       sv;
    bit       sl;
    bit       rdy;
  } vec_t;

  vec_t vq[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic add(input bit lsb, input bit rst, input bit valid, input bit [7:0] word,
                     input bit be, input bit sd, input bit sv, input bit sl, input bit rdy);
    vec_t v;
    v.lsb = lsb; v.rst = rst; v.valid = valid; v.word = word; v.be = be;
    v.sd = sd; v.sv = sv; v.sl = sl; v.rdy = rdy;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input int i, input logic got, input bit want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s vec %0d: got %b want %b", name, i, got, want);
  endtask

  initial begin
    bit [7:0]  p8;
    bit [15:0] p16;

    // A5 MSB-first with bit_en tied high
    add(0, 1, 0, 8'h00, 1, 0, 0, 0, 0);
    add(0, 0, 1, 8'hA5, 1, 0, 0, 0, 1);
    p8 = 8'b1010_0101;
    for (int i = 0; i < 8; i++) add(0, 0, 0, 8'h00, 1, p8[7-i], 1, i == 7, i == 7);
    add(0, 0, 0, 8'h00, 1, 0, 0, 0, 1);

    // back-to-back 01 then FF, in_valid held through the first word
    add(0, 0, 1, 8'h01, 1, 0, 0, 0, 1);
    p16 = 16'b0000_0001_1111_1111;
    for (int i = 0; i < 16; i++)
      add(0, 0, i < 8, 8'hFF, 1, p16[15-i], 1, i == 7 || i == 15, i == 7 || i == 15);
    add(0, 0, 0, 8'h00, 1, 0, 0, 0, 1);

    // 3C with bit_en alternating 0,1; in_word corrupted after the handshake
    add(0, 0, 1, 8'h3C, 1, 0, 0, 0, 1);
    p8 = 8'b0011_1100;
    for (int k = 0; k < 16; k++)
      add(0, 0, 0, 8'hFF, k[0], p8[7-k/2], 1, k >= 14, k == 15);
    add(0, 0, 0, 8'h00, 0, 0, 0, 0, 1);

    // F0 aborted by reset after three bits, then 0F in full
    add(0, 0, 1, 8'hF0, 1, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 8'h00, 1, 1, 1, 0, 0);
    add(0, 1, 0, 8'h00, 1, 1, 1, 0, 0);
    add(0, 0, 1, 8'h0F, 1, 0, 0, 0, 1);
    p8 = 8'b0000_1111;
    for (int i = 0; i < 8; i++) add(0, 0, 0, 8'h00, 1, p8[7-i], 1, i == 7, i == 7);
    add(0, 0, 0, 8'h00, 1, 0, 0, 0, 1);

    // LSB-first instance: 01 then 80
    add(1, 1, 0, 8'h00, 1, 0, 0, 0, 0);
    add(1, 0, 1, 8'h01, 1, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) add(1, 0, 0, 8'h00, 1, i == 0, 1, i == 7, i == 7);
    add(1, 0, 1, 8'h80, 1, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) add(1, 0, 0, 8'h00, 1, i == 7, 1, i == 7, i == 7);
    add(1, 0, 0, 8'h00, 1, 0, 0, 0, 1);

    bus_m.in_valid = 1'b0; bus_m.in_word = '0; bus_m.bit_en = 1'b0;
    bus_l.in_valid = 1'b0; bus_l.in_word = '0; bus_l.bit_en = 1'b0;

    // Each vector holds the inputs for one cycle and the outputs expected in that
    // same cycle, sampled mid-cycle before the next rising edge.
    foreach (vq[i]) begin
      @(negedge clk);
      reset          = vq[i].rst;
      bus_m.in_valid = vq[i].valid; bus_m.in_word = vq[i].word; bus_m.bit_en = vq[i].be;
      bus_l.in_valid = vq[i].valid; bus_l.in_word = vq[i].word; bus_l.bit_en = vq[i].be;
      #1;
      if (vq[i].lsb) begin
        chk("lsb ser_data",  i, bus_l.ser_data,  vq[i].sd);
        chk("lsb ser_valid", i, bus_l.ser_valid, vq[i].sv);
        chk("lsb busy",      i, bus_l.busy,      vq[i].sv);
        chk("lsb ser_last",  i, bus_l.ser_last,  vq[i].sl);
        chk("lsb in_ready",  i, bus_l.in_ready,  vq[i].rdy);
      end else begin
        chk("msb ser_data",  i, bus_m.ser_data,  vq[i].sd);
        chk("msb ser_valid", i, bus_m.ser_valid, vq[i].sv);
        chk("msb busy",      i, bus_m.busy,      vq[i].sv);
        chk("msb ser_last",  i, bus_m.ser_last,  vq[i].sl);
        chk("msb in_ready",  i, bus_m.in_ready,  vq[i].rdy);
      end
    end

    // idle block ignores bit_en and stays ready with no frame
    @(negedge clk);
    bus_m.in_valid = 1'b0; bus_m.bit_en = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("idle ser_valid", -1, bus_m.ser_valid, 1'b0);
    chk("idle ser_data",  -1, bus_m.ser_data,  1'b0);
    chk("idle in_ready",  -1, bus_m.in_ready,  1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
